// File: rtl/add_issue_if.sv
// add_issue_if: bundle of the command, adder and result signals around the
// add_issue stage.
//   slave  modport : the issue stage itself (takes commands, drives the adder,
//                    presents results).
//   master modport : the environment (command producer, adder, result consumer).
// Signals:
//   in_valid/in_ready/in_a/in_b/in_bitnum/in_acc : command handshake and payload
//   add_a/add_b/add_bitnum                        : operands towards the adder
//   add_sum                                       : adder result, same cycle
//   out_valid/out_ready/out_sum                   : held-result handshake
//   count                                         : command FIFO occupancy
interface add_issue_if #(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_a;
    logic [15:0]      in_b;
    logic [1:0]       in_bitnum;
    logic             in_acc;
    logic [15:0]      add_a;
    logic [15:0]      add_b;
    logic [1:0]       add_bitnum;
    logic [15:0]      add_sum;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_sum;
    logic [CNT_W-1:0] count;

    modport slave (
        input  in_valid, in_a, in_b, in_bitnum, in_acc, add_sum, out_ready,
        output in_ready, add_a, add_b, add_bitnum, out_valid, out_sum, count
    );

    modport master (
        output in_valid, in_a, in_b, in_bitnum, in_acc, add_sum, out_ready,
        input  in_ready, add_a, add_b, add_bitnum, out_valid, out_sum, count
    );
endinterface

// File: rtl/add_issue.sv
// add_issue: operand issue and result-capture stage in front of the packed-lane
// adder. Commands are queued in a DEPTH-entry FIFO; the head drives the adder
// combinationally and the adder's sum is captured into a held output register
// whenever the head can be issued. An accumulate flag replaces operand A with
// the previously captured sum so multi-word lane sums chain in hardware.
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : synchronous active-high reset
//   bus  : add_issue_if.slave (command in, adder drive, result out, count)
module add_issue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    add_issue_if.slave  bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef struct packed {
        logic        acc;
        logic [1:0]  bitnum;
        logic [15:0] a;
        logic [15:0] b;
    } cmd_t;

    cmd_t        mem_q [DEPTH];

    // Pointers carry one extra wrap bit so full and empty differ only in it.
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        out_valid_q, out_valid_d;
    logic [15:0] out_sum_q, out_sum_d;
    logic [15:0] last_sum_q, last_sum_d;

    logic             empty;
    logic             full;
    logic             push;
    logic             issue;
    logic [CNT_W-1:0] count;
    cmd_t             head;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count = wr_ptr_q - rd_ptr_q;

    // Acceptance looks only at the current occupancy, never at a same-cycle
    // pop, which keeps out_ready off the in_ready path.
    assign push  = bus.in_valid && !full;
    assign issue = !empty && (!out_valid_q || bus.out_ready);

    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    // Adder operands follow the head every cycle; zeros when nothing is queued.
    assign bus.add_a      = empty ? 16'h0000 : (head.acc ? last_sum_q : head.a);
    assign bus.add_b      = empty ? 16'h0000 : head.b;
    assign bus.add_bitnum = empty ? 2'b00    : head.bitnum;

    assign bus.in_ready  = !full;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.count     = count;

    // Command storage; the pointers guard validity so no reset is needed here.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_ptr_q[AW-1:0]] <= '{acc:    bus.in_acc,
                                         bitnum: bus.in_bitnum,
                                         a:      bus.in_a,
                                         b:      bus.in_b};
        end
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        last_sum_d  = last_sum_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end

        if (issue) begin
            rd_ptr_d    = rd_ptr_q + PTR_ONE;
            out_sum_d   = bus.add_sum;
            last_sum_d  = bus.add_sum;
            out_valid_d = 1'b1;
        end else if (out_valid_q && bus.out_ready) begin
            // Result consumed with nothing to replace it; out_sum keeps its value.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= 16'h0000;
            last_sum_q  <= 16'h0000;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            last_sum_q  <= last_sum_d;
        end
    end
endmodule
